// File: rtl/bram_pkg.sv
// Shared constants, clear-FSM states and byte-merge
// helper for the parametrised dual-port buffer.
package bram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Widest word the merge helper handles.
    localparam int BRAM_MAX_W = 1024;

    typedef enum logic {
        CLR_IDLE,
        CLR_CLEAR
    } clr_state_e;

    // Replace each byte lane of old_w whose be bit is set.
    function automatic logic [BRAM_MAX_W-1:0] byte_merge(
        input logic [BRAM_MAX_W-1:0]   old_w,
        input logic [BRAM_MAX_W-1:0]   new_w,
        input logic [BRAM_MAX_W/8-1:0] be
    );
        logic [BRAM_MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BRAM_MAX_W / 8; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_dpm_param_if.sv
// Both access ports of the dual-port buffer.
// master = requester side, slave = the RAM.
interface bram_dpm_param_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
);
    logic                en_a;
    logic                we_a;
    logic [DATA_W/8-1:0] be_a;
    logic [ADDR_W-1:0]   addr_a;
    logic [DATA_W-1:0]   din_a;
    logic [DATA_W-1:0]   dout_a;
    logic                vld_a;

    logic                en_b;
    logic                we_b;
    logic [DATA_W/8-1:0] be_b;
    logic [ADDR_W-1:0]   addr_b;
    logic [DATA_W-1:0]   din_b;
    logic [DATA_W-1:0]   dout_b;
    logic                vld_b;

    modport master (
        output en_a, we_a, be_a, addr_a, din_a,
        output en_b, we_b, be_b, addr_b, din_b,
        input  dout_a, vld_a, dout_b, vld_b
    );

    modport slave (
        input  en_a, we_a, be_a, addr_a, din_a,
        input  en_b, we_b, be_b, addr_b, din_b,
        output dout_a, vld_a, dout_b, vld_b
    );
endinterface

// File: rtl/bram_clr_seq.sv
// Clear sequencer: sweeps addresses 0..DEPTH-1,
// one word per cycle, through port A's write path.
module bram_clr_seq
    import bram_pkg::*;
#(
    parameter int DEPTH  = 1040,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next state and sweep address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // State and counter; reset aborts a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_busy = (state_q == CLR_CLEAR);
    assign clr_we   = clr_busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/bram_dpm_param.sv
// True dual-port sector buffer with byte enables,
// clear sweep, collision and range reporting.
module bram_dpm_param
    import bram_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              DEPTH     = 1040,
    parameter int              ADDR_W    = 11,
    parameter int              RDW_MODE  = RDW_WRITE_FIRST,
    parameter int              OUT_REG   = 0,
    parameter string           INIT_FILE = "",
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_dpm_param_if.slave   bus,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              collision,
    output logic              range_err
);

    localparam int BE_W = DATA_W / 8;

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] o,
        input logic [DATA_W-1:0] n,
        input logic [BE_W-1:0]   b
    );
        return DATA_W'(byte_merge(BRAM_MAX_W'(o),
                                  BRAM_MAX_W'(n),
                                  (BRAM_MAX_W/8)'(b)));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]                en, we;
    logic [1:0][BE_W-1:0]      be;
    logic [1:0][ADDR_W-1:0]    addr;
    logic [1:0][DATA_W-1:0]    din;

    assign en   = {bus.en_b,   bus.en_a};
    assign we   = {bus.we_b,   bus.we_a};
    assign be   = {bus.be_b,   bus.be_a};
    assign addr = {bus.addr_b, bus.addr_a};
    assign din  = {bus.din_b,  bus.din_a};

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    bram_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic [1:0]             acc, oor, uw;
    logic [1:0][DATA_W-1:0] old, mrg, rd;
    logic                   same;
    logic                   wa_en, wb_en;
    logic [ADDR_W-1:0]      wa_addr, wb_addr;
    logic [DATA_W-1:0]      wa_data, wb_data;
    logic                   collision_d, collision_q;
    logic                   range_err_d, range_err_q;
    logic [1:0][DATA_W-1:0] dout1_d, dout1_q;
    logic [1:0]             vld1_d, vld1_q;

    // Access qualification, read data and write muxing.
    always_comb begin
        acc     = '0;
        oor     = '0;
        uw      = '0;
        old     = '0;
        mrg     = '0;
        rd      = '0;
        dout1_d = dout1_q;
        vld1_d  = '0;
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] & ~clr_busy & ~clr_start;
            oor[p] = {1'b0, addr[p]} >= (ADDR_W+1)'(DEPTH);
            old[p] = oor[p] ? '0 : mem[addr[p]];
            mrg[p] = merge(old[p], din[p], be[p]);
            uw[p]  = acc[p] & we[p] & ~oor[p];
            rd[p]  = (uw[p] && RDW_MODE != RDW_READ_FIRST)
                     ? mrg[p] : old[p];
            if (acc[p]) dout1_d[p] = rd[p];
            vld1_d[p] = acc[p];
        end
        same = uw[0] & uw[1] & (addr[0] == addr[1]);
        collision_d = same & (|(be[0] & be[1]));
        range_err_d = |(acc & oor);
        wa_en   = clr_we | uw[0];
        wa_addr = clr_we ? clr_addr : addr[0];
        if (clr_we) begin
            wa_data = CLR_VALUE;
        end else if (same) begin
            wa_data = merge(mrg[1], din[0], be[0]);
        end else begin
            wa_data = mrg[0];
        end
        wb_en   = uw[1] & ~same;
        wb_addr = addr[1];
        wb_data = mrg[1];
    end

    // Array update; port A carries merged double writes.
    always_ff @(posedge clk) begin
        if (wa_en) mem[wa_addr] <= wa_data;
        if (wb_en) mem[wb_addr] <= wb_data;
    end

    // First read stage and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1_q     <= '0;
            vld1_q      <= '0;
            collision_q <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            dout1_q     <= dout1_d;
            vld1_q      <= vld1_d;
            collision_q <= collision_d;
            range_err_q <= range_err_d;
        end
    end

    assign collision = collision_q;
    assign range_err = range_err_q;

    if (OUT_REG != 0) begin : g_oreg
        logic [1:0][DATA_W-1:0] dout2_d, dout2_q;
        logic [1:0]             vld2_d, vld2_q;

        // Second stage follows the first one cycle later.
        always_comb begin
            dout2_d = dout2_q;
            vld2_d  = vld1_q;
            for (int p = 0; p < 2; p++) begin
                if (vld1_q[p]) dout2_d[p] = dout1_q[p];
            end
        end

        // Output register bank.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout2_q <= '0;
                vld2_q  <= '0;
            end else begin
                dout2_q <= dout2_d;
                vld2_q  <= vld2_d;
            end
        end

        assign bus.dout_a = dout2_q[0];
        assign bus.dout_b = dout2_q[1];
        assign bus.vld_a  = vld2_q[0];
        assign bus.vld_b  = vld2_q[1];
    end else begin : g_noreg
        assign bus.dout_a = dout1_q[0];
        assign bus.dout_b = dout1_q[1];
        assign bus.vld_a  = vld1_q[0];
        assign bus.vld_b  = vld1_q[1];
    end

endmodule

// File: tb/tb_bram_dpm_param.sv
// Bench: write-first/no-outreg and read-first/outreg
// instances driven identically, checked against a word model.
module tb_bram_dpm_param;
    import bram_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 1040;
    localparam int AW    = 11;
    localparam logic [63:0] CLRV = 64'hC1EA_5A5A_0F0F_D00D;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr_start = 1'b0;
    logic busy0, col0, rng0;
    logic busy1, col1, rng1;

    always #5 clk = ~clk;

    bram_dpm_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    bram_dpm_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    bram_dpm_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW),
        .RDW_MODE(RDW_WRITE_FIRST), .OUT_REG(0),
        .INIT_FILE(""), .CLR_VALUE(CLRV)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .clr_start(clr_start), .clr_busy(busy0),
        .collision(col0), .range_err(rng0)
    );

    bram_dpm_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW),
        .RDW_MODE(RDW_READ_FIRST), .OUT_REG(1),
        .INIT_FILE(""), .CLR_VALUE(CLRV)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .clr_start(clr_start), .clr_busy(busy1),
        .collision(col1), .range_err(rng1)
    );

    int checks = 0;
    int errors = 0;

    // reference model
    logic [63:0] mem_m [DEPTH];
    int          clr_left = 0;
    int          clr_ptr  = 0;
    logic [63:0] e0_d [2];
    bit          e0_v [2];
    logic [63:0] e1_s [2];
    bit          e1_sv [2];
    logic [63:0] e1_d [2];
    bit          e1_v [2];
    bit          e_col, e_rng, e_busy;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = 0;
        clr_ptr  = 0;
        e_col = 0; e_rng = 0; e_busy = 0;
        for (int p = 0; p < 2; p++) begin
            e0_d[p] = '0; e0_v[p] = 0;
            e1_s[p] = '0; e1_sv[p] = 0;
            e1_d[p] = '0; e1_v[p] = 0;
        end
    endtask

    task automatic check_all();
        chk("d0_dout_a", bus0.dout_a, e0_d[0]);
        chk("d0_dout_b", bus0.dout_b, e0_d[1]);
        chk("d0_vld_a", 64'(bus0.vld_a), 64'(e0_v[0]));
        chk("d0_vld_b", 64'(bus0.vld_b), 64'(e0_v[1]));
        chk("d1_dout_a", bus1.dout_a, e1_d[0]);
        chk("d1_dout_b", bus1.dout_b, e1_d[1]);
        chk("d1_vld_a", 64'(bus1.vld_a), 64'(e1_v[0]));
        chk("d1_vld_b", 64'(bus1.vld_b), 64'(e1_v[1]));
        chk("d0_collision", 64'(col0), 64'(e_col));
        chk("d1_collision", 64'(col1), 64'(e_col));
        chk("d0_range_err", 64'(rng0), 64'(e_rng));
        chk("d1_range_err", 64'(rng1), 64'(e_rng));
        chk("d0_clr_busy", 64'(busy0), 64'(e_busy));
        chk("d1_clr_busy", 64'(busy1), 64'(e_busy));
    endtask

    task automatic drive(
        input bit ea, input bit wa, input logic [7:0] bea,
        input logic [10:0] aa, input logic [63:0] da,
        input bit eb, input bit wb, input logic [7:0] beb,
        input logic [10:0] ab, input logic [63:0] db,
        input bit cs
    );
        bus0.en_a = ea; bus0.we_a = wa; bus0.be_a = bea;
        bus0.addr_a = aa; bus0.din_a = da;
        bus0.en_b = eb; bus0.we_b = wb; bus0.be_b = beb;
        bus0.addr_b = ab; bus0.din_b = db;
        bus1.en_a = ea; bus1.we_a = wa; bus1.be_a = bea;
        bus1.addr_a = aa; bus1.din_a = da;
        bus1.en_b = eb; bus1.we_b = wb; bus1.be_b = beb;
        bus1.addr_b = ab; bus1.din_b = db;
        clr_start = cs;
    endtask

    // One clock edge of the behavioural model.
    task automatic model(
        input bit ea, input bit wa, input logic [7:0] bea,
        input logic [10:0] aa, input logic [63:0] da,
        input bit eb, input bit wb, input logic [7:0] beb,
        input logic [10:0] ab, input logic [63:0] db,
        input bit cs
    );
        bit          en [2], we [2], acc [2], oor [2], wr [2];
        logic [7:0]  be [2];
        int          ad [2];
        logic [63:0] dn [2], old [2], mrg [2];
        bit          busy;
        en[0] = ea; we[0] = wa; be[0] = bea; ad[0] = int'(aa); dn[0] = da;
        en[1] = eb; we[1] = wb; be[1] = beb; ad[1] = int'(ab); dn[1] = db;
        busy = (clr_left > 0);
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] && !busy && !cs;
            oor[p] = ad[p] >= DEPTH;
            old[p] = oor[p] ? 64'h0 : mem_m[ad[p]];
            mrg[p] = old[p];
            for (int i = 0; i < 8; i++)
                if (be[p][i]) mrg[p][8*i +: 8] = dn[p][8*i +: 8];
            wr[p] = acc[p] && we[p] && !oor[p];
            if (e1_sv[p]) e1_d[p] = e1_s[p];
            e1_v[p]  = e1_sv[p];
            e1_sv[p] = acc[p];
            if (acc[p]) e1_s[p] = old[p];
            e0_v[p] = acc[p];
            if (acc[p]) e0_d[p] = wr[p] ? mrg[p] : old[p];
        end
        e_col = wr[0] && wr[1] && ad[0] == ad[1] && (be[0] & be[1]) != 0;
        e_rng = (acc[0] && oor[0]) || (acc[1] && oor[1]);
        if (busy) begin
            mem_m[clr_ptr] = CLRV;
            clr_ptr++;
            clr_left--;
        end else if (cs) begin
            clr_left = DEPTH;
            clr_ptr  = 0;
        end else begin
            for (int p = 1; p >= 0; p--)
                if (wr[p])
                    for (int i = 0; i < 8; i++)
                        if (be[p][i])
                            mem_m[ad[p]][8*i +: 8] = dn[p][8*i +: 8];
        end
        e_busy = (clr_left > 0);
    endtask

    task automatic step(
        input bit ea, input bit wa, input logic [7:0] bea,
        input logic [10:0] aa, input logic [63:0] da,
        input bit eb, input bit wb, input logic [7:0] beb,
        input logic [10:0] ab, input logic [63:0] db,
        input bit cs
    );
        @(negedge clk);
        drive(ea, wa, bea, aa, da, eb, wb, beb, ab, db, cs);
        @(posedge clk);
        model(ea, wa, bea, aa, da, eb, wb, beb, ab, db, cs);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_a(input logic [10:0] a, input logic [63:0] d,
                        input logic [7:0] b);
        step(1, 1, b, a, d, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_ab(input logic [10:0] a, input logic [10:0] b);
        step(1, 0, 0, a, 0, 1, 0, 0, b, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    function automatic logic [10:0] raddr();
        if ($urandom_range(0, 7) == 0)
            return 11'(1040 + $urandom_range(0, 1007));
        return 11'($urandom_range(0, 15));
    endfunction

    initial begin
        int busy_cnt;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        do_reset();

        // full clear; start edge also carries a dropped write
        busy_cnt = 0;
        step(1, 1, 8'hFF, 11'd30, 64'h3030, 0, 0, 0, 0, 0, 1);
        busy_cnt += int'(busy0);
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 5)
                step(1, 1, 8'hFF, 11'd20, 64'hDEAD, 0, 0, 0, 0, 0, 0);
            else if (i == 6)
                step(0, 0, 0, 0, 0, 1, 1, 8'hFF, 11'd21, 64'hBEEF, 1);
            else
                idle();
            busy_cnt += int'(busy0);
        end
        chk("clr_cycles", 64'(busy_cnt), 64'd1040);
        rd_ab(11'd0, 11'd1039);
        chk("clr_addr0", bus0.dout_a, CLRV);
        chk("clr_addr1039", bus0.dout_b, CLRV);
        rd_ab(11'd20, 11'd30);
        chk("clr_drop20", bus0.dout_a, CLRV);
        chk("clr_drop30", bus0.dout_b, CLRV);

        // write-first, full word
        wr_a(11'd5, 64'h1122334455667788, 8'hFF);
        rd_ab(11'd5, 11'd0);
        chk("wf_read5", bus0.dout_a, 64'h1122334455667788);
        chk("wf_vld5", 64'(bus0.vld_a), 64'd1);

        // byte enables
        wr_a(11'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr_a(11'd9, 64'h0, 8'h0F);
        rd_ab(11'd9, 11'd9);
        chk("be_read9", bus0.dout_a, 64'hFFFFFFFF00000000);

        // read-first vs write-first on the same port
        wr_a(11'd3, 64'h5555_5555_5555_5555, 8'hFF);
        wr_a(11'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        chk("wf_same", bus0.dout_a, 64'hAAAA_AAAA_AAAA_AAAA);
        idle();
        chk("rf_same", bus1.dout_a, 64'h5555_5555_5555_5555);
        rd_ab(11'd3, 11'd3);
        idle();
        chk("rf_next", bus1.dout_a, 64'hAAAA_AAAA_AAAA_AAAA);

        // cross-port read of a word being written
        step(1, 1, 8'hFF, 11'd4, 64'h4444, 1, 0, 0, 11'd4, 0, 0);
        chk("xport_old", bus0.dout_b, CLRV);

        // collisions
        step(1, 1, 8'hFF, 11'd7, 64'h1, 1, 1, 8'hFF, 11'd7, 64'h2, 0);
        chk("col_pulse", 64'(col0), 64'd1);
        idle();
        chk("col_end", 64'(col0), 64'd0);
        rd_ab(11'd7, 11'd7);
        chk("col_a_wins", bus0.dout_a, 64'h1);
        step(1, 1, 8'h0F, 11'd7, 64'h1111_1111_1111_1111,
             1, 1, 8'hF0, 11'd7, 64'h2222_2222_2222_2222, 0);
        chk("col_none", 64'(col0), 64'd0);
        rd_ab(11'd7, 11'd0);
        chk("col_merge", bus0.dout_a, 64'h2222222211111111);

        // out of range
        rd_ab(11'd1040, 11'd0);
        chk("rng_dout", bus0.dout_a, 64'h0);
        chk("rng_vld", 64'(bus0.vld_a), 64'd1);
        chk("rng_pulse", 64'(rng0), 64'd1);
        step(0, 0, 0, 0, 0, 1, 1, 8'hFF, 11'd1040, 64'h9999, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 8'($urandom), raddr(), {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 8'($urandom), raddr(), {$urandom, $urandom}, 0);
        end

        // sweep every word through both ports
        for (int i = 0; i < DEPTH; i += 2)
            rd_ab(11'(i), 11'(i + 1));

        // reset in the middle of a clear
        wr_a(11'd99, 64'h0099_0099_0099_0099, 8'hFF);
        wr_a(11'd500, 64'h0500_0500_0500_0500, 8'hFF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 105; i++) idle();
        do_reset();
        rd_ab(11'd99, 11'd500);
        chk("abort_99", bus0.dout_a, CLRV);
        chk("abort_500", bus0.dout_b, 64'h0500_0500_0500_0500);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
